// File: rtl/spram_fifo_pkg.sv
// spram_fifo_pkg
//   Shared constants and helpers for the single-port-RAM stream FIFO
//   controller and its output skid buffer.
//     RAM_RD_LATENCY : cycles from address to registered RAM data (1)
//     SKID_DEPTH     : entries in the output skid buffer (2)
//     OCC_W          : width of the skid occupancy / pending-read sum
//     count_width()  : width of the total-occupancy counter
package spram_fifo_pkg;

  localparam int RAM_RD_LATENCY = 1;
  localparam int SKID_DEPTH     = 2;

  // Wide enough for skid occupancy plus any reads still in the RAM pipe.
  localparam int OCC_W = $clog2(SKID_DEPTH + RAM_RD_LATENCY + 1);

  // Total storage is DEPTH + SKID_DEPTH, so two extra bits cover 0..DEPTH+2.
  function automatic int count_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// fifo_skid_buffer
//   Two-entry FIFO that catches words returning from the RAM. Push and pop
//   may happen in the same cycle. The caller never pushes when full and
//   never pops when empty.
//   Ports:
//     clock      in   rising-edge clock
//     clear      in   asynchronous active-low reset (control state only)
//     push       in   store push_data this cycle
//     push_data  in   word to store
//     pop        in   drop the head entry this cycle
//     head       out  oldest stored word
//     occupancy  out  number of stored words (0..SKID_DEPTH)
import spram_fifo_pkg::*;

module fifo_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] slot [SKID_DEPTH];
  logic                  wr_idx;
  logic                  rd_idx;
  logic [OCC_W-1:0]      occ;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) wr_idx <= ~wr_idx;
      if (pop)  rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is data only; validity is carried entirely by occ.
  always_ff @(posedge clock) begin
    if (push) slot[wr_idx] <= push_data;
  end

  assign head      = slot[rd_idx];
  assign occupancy = occ;

endmodule

// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl
//   Stream FIFO controller driving one external single-port RAM. Writes and
//   prefetch reads share the RAM port, alternating when both are pending.
//   Words returning from the RAM (one cycle after the read address) land in
//   a two-entry skid buffer that presents the head word downstream.
//   Ports:
//     clock     in   rising-edge clock, also clocks the RAM
//     clear     in   asynchronous active-low reset
//     wr_valid  in   upstream word present
//     wr_ready  out  word on wr_data accepted this cycle
//     wr_data   in   upstream word
//     rd_valid  out  rd_data holds the head word
//     rd_ready  in   downstream takes the head word
//     rd_data   out  head word (0 when rd_valid is low)
//     count     out  words held: RAM + in-flight read + skid buffer
//     ram_addr  out  RAM address
//     ram_data  out  RAM write data
//     ram_we    out  RAM write enable
//     ram_out   in   registered RAM read data
import spram_fifo_pkg::*;

module spram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [count_width(ADDR_WIDTH)-1:0] count,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_data,
  output logic                              ram_we,
  input  logic [DATA_WIDTH-1:0]             ram_out
);

  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam int                    CNT_W    = count_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   RAM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  last_rd;
  logic [CNT_W-1:0]      count_r;
  logic                  inflight_p1;

  logic [OCC_W-1:0]      buf_cnt;
  logic [OCC_W-1:0]      pending;
  logic [DATA_WIDTH-1:0] head;
  logic                  want_rd;
  logic                  want_wr;
  logic                  wr_fire;
  logic                  rd_issue;
  logic                  rd_pop;

  // Stage p0: arbitration and RAM port drive
  // A read is only issued if the skid buffer is guaranteed room for it when
  // it returns, counting the read already travelling through the RAM.
  assign pending  = buf_cnt + OCC_W'(inflight_p1);
  assign want_rd  = (ram_cnt != '0) && (pending < OCC_W'(SKID_DEPTH));
  assign want_wr  = (ram_cnt != RAM_FULL);

  // Write loses only when a read also wants the port and the read was not
  // the last one served. Gating with clear keeps the port quiet in reset.
  assign wr_ready = clear && want_wr && !(want_rd && !last_rd);
  assign wr_fire  = wr_valid && wr_ready;
  // An idle write grant falls through to a read in the same cycle.
  assign rd_issue = want_rd && !wr_fire;

  assign ram_we   = wr_fire;
  assign ram_addr = wr_fire ? wptr : rptr;
  assign ram_data = wr_data;

  assign rd_valid = (buf_cnt != '0);
  assign rd_pop   = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? head : '0;
  assign count    = count_r;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      last_rd     <= 1'b0;
      inflight_p1 <= 1'b0;
      count_r     <= '0;
    end else begin
      if (wr_fire)  wptr <= wptr + ADDR_WIDTH'(1);
      if (rd_issue) rptr <= rptr + ADDR_WIDTH'(1);

      // wr_fire and rd_issue are mutually exclusive by construction.
      if (wr_fire)       ram_cnt <= ram_cnt + (ADDR_WIDTH + 1)'(1);
      else if (rd_issue) ram_cnt <= ram_cnt - (ADDR_WIDTH + 1)'(1);

      if (rd_issue)     last_rd <= 1'b1;
      else if (wr_fire) last_rd <= 1'b0;

      inflight_p1 <= rd_issue;

      case ({wr_fire, rd_pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Stage p1: RAM data returns and is captured by the skid buffer
  fifo_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clock     (clock),
    .clear     (clear),
    .push      (inflight_p1),
    .push_data (ram_out),
    .pop       (rd_pop),
    .head      (head),
    .occupancy (buf_cnt)
  );

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl with ADDR_WIDTH=2 (DEPTH=4) and a behavioural
// single-port RAM. The reference model is a plain queue of accepted words:
// every accepted write is pushed, every downstream transfer must match the
// oldest entry, and count must equal the queue length.
module tb_spram_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int CAP   = DEPTH + 2;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_out;

  always #5 clock = ~clock;

  spram_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .ram_out  (ram_out)
  );

  // single_port_ram: synchronous write, registered read.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_out <= ram_mem[ram_addr];
  end

  int            checks = 0;
  int            passes = 0;
  logic [DW-1:0] exp_q [$];
  int            n_out = 0;
  int            wr_total = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  int            acc;
  bit            fired;
  bit            seen;
  bit            we_prev;
  int            base;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard input: accepted writes enter the model; the k-th write since
  // reset must land at address k mod DEPTH.
  always @(negedge clock) begin
    if (!clear) begin
      wr_total = 0;
    end else begin
      if (ram_we) begin
        chk("wr_addr", 32'(ram_addr), 32'(wr_total % DEPTH));
        wr_total++;
      end
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
    end
  end

  // Monitor: every downstream transfer pops the model; a stalled head must
  // stay valid and unchanged.
  always @(negedge clock) begin
    if (!clear) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", 32'(rd_data), 32'(data_prev));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rd_extra: got 0x%0h, expected no word", rd_data);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        n_out++;
      end
      stall_prev = rd_valid && !rd_ready;
      data_prev  = rd_data;
    end
  end

  // Occupancy: count tracks the model, and a full FIFO never accepts.
  always @(posedge clock) begin
    #2;
    if (clear) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      if (wr_ready) chk("not_full", 32'(exp_q.size() < CAP), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string nm);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int t = 0; t < 40 && (exp_q.size() != 0 || rd_valid); t++) step();
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset held with a write offered: nothing may reach the RAM.
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    repeat (3) begin
      @(negedge clock);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
    end
    step();
    wr_valid = 1'b0;
    #2 clear = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", 32'(wr_ready), 32'd1);

    // Single word: accepted in cycle 0, visible in cycle 3.
    step();
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    rd_ready = 1'b1;
    @(negedge clock);
    chk("single_accept", 32'(wr_ready), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) wr_valid = 1'b0;
      @(negedge clock);
      chk("single_latency", 32'(rd_valid), 32'(k == 3));
      if (k == 3) chk("single_data", 32'(rd_data), 32'hA5);
    end
    step();
    @(negedge clock);
    chk("single_count", 32'(count), 32'd0);

    // Fill with the output blocked: capacity is DEPTH+2.
    step();
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h01;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      fired = wr_valid && wr_ready;
      if (fired) acc++;
      step();
      if (fired) begin
        if (wr_data == 8'h08) wr_valid = 1'b0;
        else wr_data = wr_data + 8'h01;
      end
    end
    @(negedge clock);
    chk("fill_accepted", 32'(acc), 32'd6);
    chk("fill_ready", 32'(wr_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd6);

    step();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    base = n_out;
    for (int t = 0; t < 10 && n_out == base; t++) step();
    seen = 1'b0;
    for (int t = 0; t < 5 && !seen; t++) begin
      if (wr_ready) seen = 1'b1;
      else step();
    end
    chk("refill_ready", 32'(seen), 32'd1);
    for (int t = 0; t < 30 && (n_out - base) < 6; t++) step();
    chk("drain_words", 32'(n_out - base), 32'd6);
    drain("drain_empty");

    // Contention: both sides always willing, RAM ops must alternate.
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 8'h40;
    acc = 0;
    we_prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i > 0) chk("alternate", 32'(ram_we != we_prev), 32'd1);
      we_prev = ram_we;
      fired = wr_valid && wr_ready;
      if (fired) acc++;
      step();
      if (fired) wr_data = wr_data + 8'h01;
    end
    chk("contend_accepted", 32'(acc), 32'd10);
    drain("contend_drain");

    // Backpressure: downstream ready toggles every cycle.
    for (int i = 0; i < 80; i++) begin
      rd_ready = (i % 2) == 0;
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = DW'($urandom);
      step();
    end
    // Fully random traffic.
    for (int i = 0; i < 300; i++) begin
      rd_ready = ($urandom_range(0, 2) != 0);
      wr_valid = ($urandom_range(0, 1) != 0);
      wr_data  = DW'($urandom);
      step();
    end
    drain("random_drain");

    // Reset mid-operation with words stored and a read travelling.
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h90;
    acc = 0;
    for (int t = 0; t < 20 && acc < 3; t++) begin
      @(negedge clock);
      fired = wr_valid && wr_ready;
      if (fired) acc++;
      step();
      if (fired) wr_data = wr_data + 8'h01;
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    step();
    #2 clear = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("mid_rst_we", 32'(ram_we), 32'd0);
    chk("mid_rst_addr", 32'(ram_addr), 32'd0);
    repeat (2) step();
    #2 clear = 1'b1;
    step();
    base = n_out;
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hC0;
    acc = 0;
    for (int t = 0; t < 20 && acc < 4; t++) begin
      @(negedge clock);
      fired = wr_valid && wr_ready;
      if (fired) acc++;
      step();
      if (fired) begin
        if (acc == 4) wr_valid = 1'b0;
        else wr_data = wr_data + 8'h01;
      end
    end
    wr_valid = 1'b0;
    for (int t = 0; t < 30 && (n_out - base) < 4; t++) step();
    repeat (4) step();
    chk("post_rst_words", 32'(n_out - base), 32'd4);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spram_fifo_ctrl.md
# spram_fifo_ctrl

Stream FIFO controller that drives one external `single_port_ram` instance as its storage. Upstream and downstream each use a valid/ready handshake. The controller shares the RAM's single port between writes and prefetch reads by alternating them, and a 2-entry output skid buffer hides the RAM's 1-cycle registered read latency. It sits directly in front of the RAM, supplying `addr`/`data`/`we` and consuming `out`.

## Interface
- `ADDR_WIDTH`, 4, RAM address width; RAM depth `DEPTH = 1 << ADDR_WIDTH`.
- `DATA_WIDTH`, 8, word width. Must match the RAM's `data_width`.
- `clock`  in  1  single clock, rising edge; also drives the attached RAM.
- `clear`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  upstream word present.
- `wr_ready`  out  1  controller accepts `wr_data` this cycle.
- `wr_data`  in  DATA_WIDTH  upstream word.
- `rd_valid`  out  1  `rd_data` holds the head word.
- `rd_ready`  in  1  downstream accepts the head word.
- `rd_data`  out  DATA_WIDTH  head word.
- `count`  out  ADDR_WIDTH+2  total stored words: RAM occupancy plus in-flight read plus skid occupancy. Range 0..DEPTH+2.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_data`  out  DATA_WIDTH  to RAM `data`.
- `ram_we`  out  1  to RAM `we`.
- `ram_out`  in  DATA_WIDTH  from RAM `out`; registered, valid the cycle after the address is presented.

## Operation
- **State:**
  - `wptr` and `rptr` (ADDR_WIDTH, wrap modulo DEPTH).
  - `ram_cnt` (0..DEPTH).
  - `inflight` flag.
  - `buf_cnt` (0..2).
  - `last_rd` arbitration bit.
- **Request signals:**
  - `want_rd = ram_cnt != 0 && buf_cnt + inflight < 2`.
  - `want_wr = ram_cnt != DEPTH`.
- **Write grant:** `wr_ready = want_wr && !(want_rd && !last_rd)`. It does not depend on `wr_valid`.
- **Write transfer:** `wr_fire = wr_valid && wr_ready`.
- **Read issue:** `rd_issue = want_rd && !wr_fire`.
- **RAM port, exactly one op per cycle:**
  - On a write: `ram_we = wr_fire`, `ram_addr = wptr`, `ram_data = wr_data`.
  - On a read: `ram_addr = rptr`, `ram_we = 0`.
  - Idle: `ram_addr = rptr`, `ram_we = 0`.
- **Arbitration:**
  - `last_rd` is set on `rd_issue` and cleared on `wr_fire`.
  - When both sides contend, the side not served last wins, which gives strict alternation.
- **Read return:** `inflight` is set on `rd_issue`. In the next cycle `ram_out` is pushed into the skid buffer and `inflight` clears.
- **Skid buffer:** 2-entry FIFO. Push and pop may occur in the same cycle. `rd_data` is the head entry, and it is held stable while `rd_valid && !rd_ready`.
- **Counters:**
  - `ram_cnt` changes by +`wr_fire` and −`rd_issue`.
  - `count` changes by +`wr_fire` and −`(rd_valid && rd_ready)`.
- **Full/empty:**
  - `wr_ready` is low when `ram_cnt == DEPTH`.
  - `rd_valid` is low when the skid buffer is empty.
  - No overflow or underflow is possible, and no error output is required.
- **Reset:** while `clear == 0` the following hold:
  - all pointers, counters, `inflight`, `last_rd` are 0;
  - `rd_valid` is 0, `rd_data` is 0;
  - `wr_ready` is forced to 0, so `ram_we` is 0; `ram_addr` is 0.
- **Reset mid-operation:** an in-flight read and all stored words are discarded. RAM contents become don't-care.

## Timing
- **First-word latency:**
  - cycle 0: write accepted;
  - cycle 1: read issued;
  - cycle 2: `ram_out` valid, pushed into the skid buffer at the end of the cycle;
  - cycle 3: `rd_valid` = 1. Latency is 3 cycles.
- **Throughput:**
  - Sustained simultaneous write and read runs at 1 word per 2 cycles.
  - A write-only burst runs at 1 word per cycle while the skid buffer and `inflight` are saturated.
- **Capacity:** DEPTH+2 words.
- **Same-address case:** a read of an address written in the previous cycle returns the new data, since RAM write and read use separate cycles.

## Structure
- **Package `spram_fifo_pkg`:**
  - `RAM_RD_LATENCY = 1`.
  - `SKID_DEPTH = 2`.
  - the `count` width function.
- **Sub-module `fifo_skid_buffer`:** 2-entry, parameterised by DATA_WIDTH, with push/pop/head/occupancy.
- **Top level:** pointers, arbitration and counters live in `spram_fifo_ctrl`.

## Test plan
All scenarios use ADDR_WIDTH=2 (DEPTH=4) and DATA_WIDTH=8, with a `single_port_ram` attached.
1. **Reset:** hold `clear`=0 for 3 cycles with `wr_valid`=1 → `ram_we`=0, `rd_valid`=0, `count`=0. Release → `wr_ready`=1 on the next cycle.
2. **Single word:** write 0xA5 in cycle 0 with `rd_ready`=1 → `rd_valid`=1 with `rd_data`=0xA5 in cycle 3; `count` returns 0 after the pop.
3. **Fill and drain:** with `rd_ready`=0, offer 0x01..0x08 → exactly 6 are accepted, then `wr_ready`=0 and `count`=6. Raise `rd_ready` → 0x01..0x06 appear in order, and `wr_ready` rises after the first drain.
4. **Contention and wrap:** hold `wr_valid` and `rd_ready` high for 20 cycles with an incrementing pattern → RAM ops alternate W/R, `wptr`/`rptr` wrap 3→0, and output order is preserved with no loss.
5. **Backpressure:** toggle `rd_ready` every cycle while streaming → `rd_data` is unchanged whenever `rd_valid && !rd_ready`, and no word is duplicated or dropped.
6. **Reset mid-operation:** with 3 words stored and a read in flight, pulse `clear` low mid-cycle → outputs reset asynchronously; after release, only words written post-reset are read out.
